// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the round-robin adder arbiter.
package adder_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int DEFAULT_N_REQ = 4;
    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = 16;

    // Index width for n requesters; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr, with wrap.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             enable,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             found
);

    int              cand;
    logic [ID_W-1:0] sel;

    // Scan from the pointer upward; the first hit wins and masks the rest.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        sel   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = (int'(ptr) + i) % N_REQ;
            sel  = ID_W'(cand);
            if (enable && !found && req[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                idx        = sel;
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one external combinational adder among N_REQ requesters, one operation at a time.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W,
    localparam int ID_W = id_width(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [WIDTH-1:0]       add_a,
    output logic [WIDTH-1:0]       add_b,
    input  logic [WIDTH-1:0]       add_sum,
    output logic [ID_W-1:0]        gnt_id,
    output logic                   busy,
    output logic [CNT_W-1:0]       op_count
);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    gnt_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH-1:0]   rsp_data_q;
    logic [N_REQ-1:0]   rsp_valid_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [N_REQ-1:0]   grant;
    logic [ID_W-1:0]    win_idx;
    logic               win_found;
    logic               arb_en;
    logic               hs;
    logic               rsp_accept;
    logic [WIDTH-1:0]   sel_a, sel_b;

    // Arbitration is only offered in IDLE, and never while reset is held.
    assign arb_en = (state_q == IDLE) && !rst;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_arbiter (
        .req    (req_valid),
        .ptr    (ptr_q),
        .enable (arb_en),
        .grant  (grant),
        .idx    (win_idx),
        .found  (win_found)
    );

    // Grant only lands on a valid requester, so a found winner is a handshake.
    assign req_ready  = grant;
    assign hs         = win_found;
    assign rsp_accept = rsp_ready[gnt_q];

    // Operand mux driven by the one-hot grant.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> CALC on handshake, CALC -> RESP always, RESP -> IDLE on accept.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (hs) state_d = CALC;
            CALC:    state_d = RESP;
            RESP:    if (rsp_accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture operands and winner index at the request handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            gnt_q <= '0;
        end else if (state_q == IDLE && hs) begin
            a_q   <= sel_a;
            b_q   <= sel_b;
            gnt_q <= win_idx;
        end
    end

    // Sample the adder in CALC and hold the response until the granted requester takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data_q  <= '0;
            rsp_valid_q <= '0;
        end else if (state_q == CALC) begin
            rsp_data_q  <= add_sum;
            rsp_valid_q <= N_REQ'(1) << gnt_q;
        end else if (state_q == RESP && rsp_accept) begin
            rsp_valid_q <= '0;
        end
    end

    // On completion, count the operation and move priority just past the served requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            ptr_q <= '0;
        end else if (state_q == RESP && rsp_accept) begin
            cnt_q <= cnt_q + CNT_W'(1);
            ptr_q <= (gnt_q == ID_W'(N_REQ - 1)) ? '0 : gnt_q + ID_W'(1);
        end
    end

    // Operand registers feed the adder continuously, so it stays quiet outside CALC.
    assign add_a     = a_q;
    assign add_b     = b_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_valid = rsp_valid_q;
    assign gnt_id    = gnt_q;
    assign busy      = (state_q != IDLE);
    assign op_count  = cnt_q;

endmodule
